cc_mem_rd_sched: RTL

//  Schedules cache-miss line fills on the memory AXI read interface of the cache controller.

---
 rtl/cc_mem_rd_sched_pkg.sv | 15 +
 rtl/cc_mem_rd_sched_if.sv | 31 +++
 rtl/cc_mem_rd_sched_tracker.sv | 71 +++++++
 rtl/cc_mem_rd_sched.sv | 96 +++++++++
 4 files changed

// File: rtl/cc_mem_rd_sched_pkg.sv
// Shared constants and types for the cache-controller memory read scheduler.
// The AR channel always requests one full cache line as a wrapping burst.
package cc_mem_rd_sched_pkg;

  localparam int         CC_BURST_LEN    = 8;
  localparam logic [3:0] CC_ARLEN        = 4'(CC_BURST_LEN - 1);
  localparam logic [2:0] CC_ARSIZE       = 3'b011;
  localparam logic [1:0] CC_ARBURST_WRAP = 2'b10;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_REQ  = 1'b1
  } ar_state_t;

endpackage

// File: rtl/cc_mem_rd_sched_if.sv
// AXI read address / read data signals between the scheduler and memory.
// master = scheduler side, slave = memory side.
interface cc_mem_rd_sched_if #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
);

  logic [ID_W-1:0]   mem_arid_o;
  logic [ADDR_W-1:0] mem_araddr_o;
  logic [3:0]        mem_arlen_o;
  logic [2:0]        mem_arsize_o;
  logic [1:0]        mem_arburst_o;
  logic              mem_arvalid_o;
  logic              mem_arready_i;
  logic              mem_rvalid_i;
  logic              mem_rlast_i;
  logic              mem_rready_o;

  modport master (
    output mem_arid_o, mem_araddr_o, mem_arlen_o, mem_arsize_o, mem_arburst_o,
    output mem_arvalid_o, mem_rready_o,
    input  mem_arready_i, mem_rvalid_i, mem_rlast_i
  );

  modport slave (
    input  mem_arid_o, mem_araddr_o, mem_arlen_o, mem_arsize_o, mem_arburst_o,
    input  mem_arvalid_o, mem_rready_o,
    output mem_arready_i, mem_rvalid_i, mem_rlast_i
  );

endinterface

// File: rtl/cc_mem_rd_sched_tracker.sv
// R-channel bookkeeping: beat index, RLAST consistency check and the count of
// bursts whose AR has been accepted but whose last beat has not yet arrived.
module cc_mem_rd_sched_tracker #(
  parameter  int MAX_OUTSTANDING = 2,
  parameter  int BURST_LEN       = 8,
  localparam int BEAT_W          = $clog2(BURST_LEN),
  localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ar_hs,
  input  logic              rvalid,
  input  logic              rlast,
  input  logic              sink_ready,
  output logic              rready,
  output logic [BEAT_W-1:0] beat_idx,
  output logic              fill_done,
  output logic [OUT_W-1:0]  outstanding,
  output logic              err_rlast
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  logic [BEAT_W-1:0] beat_reg, beat_next;
  logic [OUT_W-1:0]  out_reg, out_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic              accept;
  logic              burst_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_reg <= '0;
      out_reg  <= '0;
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      beat_reg <= beat_next;
      out_reg  <= out_next;
      done_reg <= done_next;
      err_reg  <= err_next;
    end
  end

  always_comb begin
    rready    = sink_ready & (out_reg != '0);
    accept    = rvalid & rready;
    burst_end = accept & rlast;
    beat_next = beat_reg;
    err_next  = err_reg;
    done_next = burst_end;
    out_next  = out_reg;
    // RLAST alone closes a burst, so a short or long burst resynchronises the index
    if (accept) begin
      beat_next = (rlast || beat_reg == LAST_BEAT) ? '0 : beat_reg + BEAT_W'(1);
      if (rlast != (beat_reg == LAST_BEAT))
        err_next = 1'b1;
    end
    case ({ar_hs, burst_end})
      2'b10:   out_next = out_reg + OUT_W'(1);
      2'b01:   out_next = out_reg - OUT_W'(1);
      default: out_next = out_reg;
    endcase
  end

  assign beat_idx    = beat_reg;
  assign fill_done   = done_reg;
  assign outstanding = out_reg;
  assign err_rlast   = err_reg;

endmodule

// File: rtl/cc_mem_rd_sched.sv
// Issues cache-line fill bursts on the memory AR channel from the miss queue
// and hands R-channel tracking to the burst tracker.
module cc_mem_rd_sched
  import cc_mem_rd_sched_pkg::*;
#(
  parameter  int MAX_OUTSTANDING = 2,
  parameter  int BURST_LEN       = CC_BURST_LEN,
  parameter  int ADDR_W          = 32,
  parameter  int ID_W            = 4,
  localparam int BEAT_W          = $clog2(BURST_LEN),
  localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable_i,
  input  logic               req_valid_i,
  input  logic [ADDR_W-1:0]  req_addr_i,
  output logic               req_pop_o,
  cc_mem_rd_sched_if.master  mem,
  input  logic               sink_ready_i,
  output logic [BEAT_W-1:0]  beat_idx_o,
  output logic               fill_done_o,
  output logic [OUT_W-1:0]   outstanding_o,
  output logic               err_rlast_o,
  output logic               idle_o
);

  ar_state_t         state_reg, state_next;
  logic [ADDR_W-1:0] araddr_reg, araddr_next;
  logic [OUT_W-1:0]  outstanding;
  logic              can_issue;
  logic              ar_hs;

  // AR handshake is only counted once accepted, so the cap is checked against completed issues
  assign can_issue = enable_i & req_valid_i & (outstanding < OUT_W'(MAX_OUTSTANDING));
  assign ar_hs     = (state_reg == AR_REQ) & mem.mem_arready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= AR_IDLE;
      araddr_reg <= '0;
    end else begin
      state_reg  <= state_next;
      araddr_reg <= araddr_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    araddr_next       = araddr_reg;
    req_pop_o         = 1'b0;
    mem.mem_arvalid_o = 1'b0;
    case (state_reg)
      AR_IDLE: begin
        if (can_issue) begin
          req_pop_o   = 1'b1;
          araddr_next = req_addr_i;
          state_next  = AR_REQ;
        end
      end
      AR_REQ: begin
        mem.mem_arvalid_o = 1'b1;
        if (mem.mem_arready_i)
          state_next = AR_IDLE;
      end
      default: state_next = AR_IDLE;
    endcase
  end

  assign mem.mem_arid_o    = '0;
  assign mem.mem_araddr_o  = araddr_reg;
  assign mem.mem_arlen_o   = 4'(BURST_LEN - 1);
  assign mem.mem_arsize_o  = CC_ARSIZE;
  assign mem.mem_arburst_o = CC_ARBURST_WRAP;

  cc_mem_rd_sched_tracker #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .BURST_LEN       (BURST_LEN)
  ) u_tracker (
    .clk         (clk),
    .rst         (rst),
    .ar_hs       (ar_hs),
    .rvalid      (mem.mem_rvalid_i),
    .rlast       (mem.mem_rlast_i),
    .sink_ready  (sink_ready_i),
    .rready      (mem.mem_rready_o),
    .beat_idx    (beat_idx_o),
    .fill_done   (fill_done_o),
    .outstanding (outstanding),
    .err_rlast   (err_rlast_o)
  );

  assign outstanding_o = outstanding;
  assign idle_o        = (state_reg == AR_IDLE) && (outstanding == '0);

endmodule
